// File: rtl/operand_entry.sv
// operand_entry: key FIFO feeding a signed decimal operand assembler for the calculator.
// Operator keys leave as tokens on a valid/ready port carrying the completed operand.
module operand_entry #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 6,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    input  logic [WIDTH-1:0]            ans,
    output logic                        tok_valid,
    input  logic                        tok_ready,
    output logic [3:0]                  tok_code,
    output logic [WIDTH-1:0]            tok_operand,
    output logic                        tok_empty,
    output logic [WIDTH-1:0]            disp_value,
    output logic [$clog2(DIGITS+1)-1:0] ndigits,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
    output logic                        drop,
    output logic                        sat
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(DIGITS+1);

    localparam logic [1:0] M_EMPTY = 2'd0;
    localparam logic [1:0] M_DIGIT = 2'd1;
    localparam logic [1:0] M_ANS   = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    localparam logic [3:0] K_SIGN = 4'hc;
    localparam logic [3:0] K_BACK = 4'hd;
    localparam logic [3:0] K_ANS  = 4'he;

    logic [3:0]       mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mag, mag_n;
    logic             neg, neg_n;
    logic [CW-1:0]    cnt, cnt_n, limit;
    logic [1:0]       mode, mode_n;
    logic             push, pop, full, hs, load, sat_n;
    logic [3:0]       key;

    // HOLD freezes the pop side so the pending token and its operand stay put
    assign full       = (fifo_level == LW'(DEPTH));
    assign pop        = !clear && (fifo_level != '0) && (mode != M_HOLD);
    assign push       = !clear && key_valid && (!full || pop);
    assign tok_valid  = (mode == M_HOLD);
    assign hs         = tok_valid && tok_ready;
    assign key        = mem[rptr];
    assign limit      = CW'(DIGITS) - CW'(neg);
    assign disp_value = neg ? -mag : mag;
    assign ndigits    = cnt;

    always_comb begin
        mag_n  = mag;
        neg_n  = neg;
        cnt_n  = cnt;
        mode_n = mode;
        sat_n  = 1'b0;
        load   = 1'b0;
        if (hs) begin
            mag_n  = '0;
            neg_n  = 1'b0;
            cnt_n  = '0;
            mode_n = M_EMPTY;
        end else if (pop) begin
            if (key <= 4'd9) begin
                // leading zeros widen nothing on the display, so they are not counted
                if (mode != M_ANS && cnt < limit) begin
                    mag_n  = mag * WIDTH'(10) + WIDTH'(key);
                    mode_n = M_DIGIT;
                    if (mag != '0 || key != 4'd0)
                        cnt_n = cnt + CW'(1);
                end else begin
                    sat_n = 1'b1;
                end
            end else begin
                case (key)
                    K_SIGN: begin
                        if (mode == M_EMPTY) neg_n = ~neg;
                        else                 load  = 1'b1;
                    end
                    K_BACK: begin
                        case (mode)
                            M_DIGIT: begin
                                mag_n = mag / WIDTH'(10);
                                cnt_n = (cnt == '0) ? '0 : cnt - CW'(1);
                                if (cnt <= CW'(1)) mode_n = M_EMPTY;
                            end
                            M_ANS: begin
                                mag_n  = '0;
                                cnt_n  = '0;
                                mode_n = M_EMPTY;
                            end
                            default: neg_n = 1'b0;
                        endcase
                    end
                    K_ANS: begin
                        mag_n  = ans[WIDTH-1] ? -ans : ans;
                        neg_n  = neg ^ ans[WIDTH-1];
                        mode_n = M_ANS;
                    end
                    default: load = 1'b1;
                endcase
            end
            if (load) mode_n = M_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
            mag         <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            mode        <= M_EMPTY;
            tok_code    <= '0;
            tok_operand <= '0;
            tok_empty   <= 1'b0;
            drop        <= 1'b0;
            sat         <= 1'b0;
        end else if (clear) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
            mag         <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            mode        <= M_EMPTY;
            tok_code    <= '0;
            tok_operand <= '0;
            tok_empty   <= 1'b0;
            drop        <= 1'b0;
            sat         <= 1'b0;
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            mag        <= mag_n;
            neg        <= neg_n;
            cnt        <= cnt_n;
            mode       <= mode_n;
            drop       <= key_valid && !push;
            sat        <= sat_n;
            if (load) begin
                tok_code    <= key;
                tok_operand <= disp_value;
                tok_empty   <= (mode == M_EMPTY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= key_code;
    end
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus random key streams against a sequential model.
module tb_operand_entry;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 6;
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] op;
        logic        empty;
    } tok_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              key_valid = 1'b0;
    logic [3:0]        key_code = 4'h0;
    logic [WIDTH-1:0]  ans = '0;
    logic              tok_ready = 1'b0;
    logic              tok_valid, tok_empty, drop, sat;
    logic [3:0]        tok_code;
    logic [WIDTH-1:0]  tok_operand, disp_value;
    logic [2:0]        ndigits;
    logic [3:0]        fifo_level;

    int checks = 0, errors = 0, sat_cnt = 0, drop_cnt = 0;

    // sequential reference: entry value as magnitude/sign, mode 0=empty 1=digits 2=ans
    logic [31:0] m_mag;
    bit          m_neg;
    int          m_cnt, m_mode, m_sat;
    tok_t        exp_q[$];

    operand_entry #(.WIDTH(WIDTH), .DIGITS(DIGITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .ans(ans), .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_code(tok_code),
        .tok_operand(tok_operand), .tok_empty(tok_empty), .disp_value(disp_value),
        .ndigits(ndigits), .fifo_level(fifo_level), .drop(drop), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (sat)  sat_cnt++;
        if (drop) drop_cnt++;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic flush();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        sat_cnt  = 0;
        drop_cnt = 0;
    endtask

    task automatic wait_tok(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tok_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic model_reset();
        m_mag = '0; m_neg = 1'b0; m_cnt = 0; m_mode = 0; m_sat = 0;
        exp_q.delete();
    endtask

    task automatic model_key(input logic [3:0] k);
        tok_t t;
        int   lim;
        if (k <= 4'd9) begin
            lim = DIGITS - int'(m_neg);
            if (m_mode == 2 || m_cnt >= lim) begin
                m_sat++;
            end else begin
                if (!(m_mag == 0 && k == 0)) m_cnt++;
                m_mag  = m_mag * 32'd10 + 32'(k);
                m_mode = 1;
            end
        end else if (k == 4'hc && m_mode == 0) begin
            m_neg = !m_neg;
        end else if (k == 4'hd) begin
            if (m_mode == 1) begin
                m_mag = m_mag / 32'd10;
                if (m_cnt > 0) m_cnt--;
                if (m_cnt == 0) m_mode = 0;
            end else if (m_mode == 2) begin
                m_mag = '0; m_cnt = 0; m_mode = 0;
            end else begin
                m_neg = 1'b0;
            end
        end else if (k == 4'he) begin
            m_mag  = ans[31] ? -ans : ans;
            m_neg  = m_neg ^ ans[31];
            m_mode = 2;
        end else begin
            t.code  = k;
            t.op    = m_neg ? -m_mag : m_mag;
            t.empty = (m_mode == 0);
            exp_q.push_back(t);
            m_mag = '0; m_neg = 1'b0; m_cnt = 0; m_mode = 0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tok_valid, tok_code, tok_operand, tok_empty, disp_value, ndigits, fifo_level, drop, sat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b c=%h op=%h e=%b d=%h n=%0d l=%0d dr=%b s=%b required all zero",
                     tok_valid, tok_code, tok_operand, tok_empty, disp_value, ndigits, fifo_level, drop, sat);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        flush();
        for (int k = 0; k < 4; k++) press(4'(k));
        repeat (3) tick();
        checks++;
        if (disp_value !== 32'd123 || ndigits !== 3'd3) begin
            errors++;
            $display("FAIL basic_entry got %0d/%0d required 123/3", $signed(disp_value), ndigits);
        end
        tok_ready = 1'b1;
        press(4'hb);
        wait_tok(ok);
        checks++;
        if (!ok || tok_code !== 4'hb || tok_operand !== 32'd123 || tok_empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_token got v=%b %h/%0d e=%b required b/123 e=0", tok_valid, tok_code, $signed(tok_operand), tok_empty);
        end
        tick();
        checks++;
        if (tok_valid !== 1'b0 || disp_value !== '0 || ndigits !== '0) begin
            errors++;
            $display("FAIL basic_after_hs got v=%b d=%0d n=%0d required 0", tok_valid, $signed(disp_value), ndigits);
        end
    endtask

    task automatic test_hold();
        bit ok;
        tok_ready = 1'b0;
        flush();
        press(4'hc); press(4'h4); press(4'h5); press(4'ha);
        wait_tok(ok);
        checks++;
        if (!ok || disp_value !== -32'sd45 || tok_operand !== -32'sd45 || tok_code !== 4'ha) begin
            errors++;
            $display("FAIL hold_token got v=%b d=%0d op=%0d c=%h required -45/-45/a", tok_valid, $signed(disp_value), $signed(tok_operand), tok_code);
        end
        key_valid = 1'b1;
        key_code  = 4'h7;
        for (int i = 0; i < 3; i++) begin
            tick();
            key_valid = 1'b0;
            checks++;
            if (tok_valid !== 1'b1 || tok_operand !== -32'sd45 || tok_code !== 4'ha) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got v=%b op=%0d c=%h required 1/-45/a", i, tok_valid, $signed(tok_operand), tok_code);
            end
        end
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL hold_no_pop got level %0d required 1", fifo_level);
        end
        tok_ready = 1'b1;
        tick();
        checks++;
        if (tok_valid !== 1'b0 || disp_value !== '0 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL hold_release got v=%b d=%0d l=%0d required 0/0/1", tok_valid, $signed(disp_value), fifo_level);
        end
        tick();
        checks++;
        if (disp_value !== 32'd7 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL hold_next_pop got d=%0d l=%0d required 7/0", $signed(disp_value), fifo_level);
        end
    endtask

    task automatic test_digit_limit();
        flush();
        for (int k = 1; k <= 7; k++) press(4'(k));
        repeat (3) tick();
        checks++;
        if (disp_value !== 32'd123456 || sat_cnt != 1 || ndigits !== 3'd6) begin
            errors++;
            $display("FAIL limit_pos got %0d sat=%0d n=%0d required 123456 sat=1 n=6", $signed(disp_value), sat_cnt, ndigits);
        end
        flush();
        press(4'hc);
        for (int k = 1; k <= 6; k++) press(4'(k));
        repeat (3) tick();
        checks++;
        if (disp_value !== -32'sd12345 || sat_cnt != 1) begin
            errors++;
            $display("FAIL limit_neg got %0d sat=%0d required -12345 sat=1", $signed(disp_value), sat_cnt);
        end
        flush();
        press(4'h1); press(4'h2); press(4'h3); press(4'hd);
        repeat (3) tick();
        checks++;
        if (disp_value !== 32'd12 || ndigits !== 3'd2) begin
            errors++;
            $display("FAIL backspace got %0d n=%0d required 12 n=2", $signed(disp_value), ndigits);
        end
    endtask

    task automatic test_ans();
        bit ok;
        tok_ready = 1'b0;
        flush();
        ans = -32'sd77;
        press(4'hc); press(4'he); press(4'h5); press(4'hf);
        wait_tok(ok);
        checks++;
        if (!ok || disp_value !== 32'd77 || sat_cnt != 1 || tok_code !== 4'hf || tok_operand !== 32'd77 || tok_empty !== 1'b0) begin
            errors++;
            $display("FAIL ans_token got v=%b d=%0d sat=%0d %h/%0d e=%b required 77 sat=1 f/77 e=0",
                     tok_valid, $signed(disp_value), sat_cnt, tok_code, $signed(tok_operand), tok_empty);
        end
        tok_ready = 1'b1;
        tick();
        press(4'hf);
        wait_tok(ok);
        checks++;
        if (!ok || tok_empty !== 1'b1 || tok_operand !== '0 || tok_code !== 4'hf) begin
            errors++;
            $display("FAIL bare_op got v=%b e=%b op=%0d c=%h required e=1 op=0 f", tok_valid, tok_empty, $signed(tok_operand), tok_code);
        end
        tick();
    endtask

    task automatic test_overflow();
        bit ok;
        tok_ready = 1'b0;
        flush();
        press(4'hf);
        wait_tok(ok);
        for (int i = 0; i < 9; i++) press(4'h1);
        checks++;
        if (!ok || fifo_level !== 4'd8 || drop_cnt != 1) begin
            errors++;
            $display("FAIL overflow_drop got v=%b level=%0d drops=%0d required 8/1", tok_valid, fifo_level, drop_cnt);
        end
        tok_ready = 1'b1;
        tick();
        press(4'h2);
        checks++;
        if (fifo_level !== 4'd8 || drop_cnt != 1) begin
            errors++;
            $display("FAIL full_push_pop got level=%0d drops=%0d required 8/1", fifo_level, drop_cnt);
        end
        repeat (12) tick();
        checks++;
        if (disp_value !== 32'd111111 || sat_cnt != 3 || fifo_level !== '0) begin
            errors++;
            $display("FAIL overflow_drain got %0d sat=%0d l=%0d required 111111 sat=3 l=0", $signed(disp_value), sat_cnt, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            tok_ready = 1'b0;
            flush();
            press(4'h1); press(4'h2); press(4'hb);
            wait_tok(ok);
            press(4'h3); press(4'h4); press(4'h5);
            checks++;
            if (!ok || fifo_level !== 4'd3) begin
                errors++;
                $display("FAIL mid_setup pass %0d got v=%b l=%0d required 1/3", pass, tok_valid, fifo_level);
            end
            if (pass == 0) begin
                rst = 1'b0;
                #1;
            end else begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            checks++;
            if ({tok_valid, tok_code, tok_operand, tok_empty, disp_value, ndigits, fifo_level, drop, sat} !== '0) begin
                errors++;
                $display("FAIL mid_flush pass %0d got v=%b c=%h op=%h e=%b d=%h n=%0d l=%0d required all zero",
                         pass, tok_valid, tok_code, tok_operand, tok_empty, disp_value, ndigits, fifo_level);
            end
            rst = 1'b1;
            tick();
            press(4'h7);
            repeat (3) tick();
            checks++;
            if (disp_value !== 32'd7 || ndigits !== 3'd1 || fifo_level !== '0 || tok_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_restart pass %0d got d=%0d n=%0d l=%0d v=%b required 7/1/0/0",
                         pass, $signed(disp_value), ndigits, fifo_level, tok_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int         left;
            bit         done;
            tok_t       t;
            logic [3:0] k;
            logic [31:0] exp_disp;
            tok_ready = 1'b0;
            flush();
            model_reset();
            if (b == 5)          ans = 32'h8000_0000;
            else if (b % 2 == 1) ans = $urandom;
            else                 ans = $urandom_range(0, 2000) - 32'd1000;
            left = 40;
            done = 1'b0;
            for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
                tok_ready = ($urandom_range(0, 2) != 0) || (left == 0);
                if (tok_valid && tok_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra_token got %h/%0d required none", tok_code, $signed(tok_operand));
                    end else begin
                        t = exp_q.pop_front();
                        if ({tok_code, tok_operand, tok_empty} !== {t.code, t.op, t.empty}) begin
                            errors++;
                            $display("FAIL rand_token got %h/%0d e=%b required %h/%0d e=%b",
                                     tok_code, $signed(tok_operand), tok_empty, t.code, $signed(t.op), t.empty);
                        end
                    end
                end
                if (left > 0 && fifo_level <= DEPTH - 3 && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 9) < 6) k = 4'($urandom_range(0, 9));
                    else                          k = 4'($urandom_range(10, 15));
                    key_valid = 1'b1;
                    key_code  = k;
                    model_key(k);
                    left--;
                end
                tick();
                key_valid = 1'b0;
                if (left == 0 && fifo_level == '0 && !tok_valid) done = 1'b1;
            end
            exp_disp = m_neg ? -m_mag : m_mag;
            checks++;
            if (!done || disp_value !== exp_disp || ndigits !== 3'(m_cnt) || sat_cnt != m_sat
                || drop_cnt != 0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL rand_batch %0d got done=%b d=%0d n=%0d sat=%0d drop=%0d left_tok=%0d required d=%0d n=%0d sat=%0d",
                         b, done, $signed(disp_value), ndigits, sat_cnt, drop_cnt, exp_q.size(),
                         $signed(exp_disp), m_cnt, m_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_digit_limit();
        test_ans();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_entry.md
# operand_entry

Parametrised keypad operand-entry unit for the calculator datapath. It buffers extended-BCD key tokens from `keypad_driver` in a FIFO and assembles signed decimal operands, with sign toggle, backspace, ANS recall and a digit-count limit. Operator keys are forwarded as tokens over a valid/ready handshake, each with its completed operand. The block sits between `keypad_driver` and the calculator control FSM and replaces the ad-hoc 28-bit shift buffer and counter; it also drives the operand shown on the display.

## Interface
- `WIDTH`, 32: operand width, two's complement; must satisfy 10^DIGITS < 2^(WIDTH-1).
- `DIGITS`, 6: number of display digits. A positive entry may hold DIGITS digits; a negative entry may hold DIGITS-1.
- `DEPTH`, 8: key FIFO depth; power of two, ≥2.
- `clk` in 1: system clock (sw_clk domain), rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous flush of the FIFO, the entry and any pending token.
- `key_valid` in 1: one-cycle strobe carrying a new key.
- `key_code` in 4: eBCD code. 0–9 are digits; `a` is ÷/%; `b` is ×; `c` is ±; `d` is backspace; `e` is ANS; `f` is =.
- `ans` in WIDTH: last result, sampled when ANS is popped.
- `tok_valid` out 1: an operator token is pending.
- `tok_ready` in 1: the consumer accepts the token.
- `tok_code` out 4: operator code (`a`, `b`, `c` or `f`).
- `tok_operand` out WIDTH: signed operand completed by this operator.
- `tok_empty` out 1: no operand was entered before this operator.
- `disp_value` out WIDTH: current signed entry value.
- `ndigits` out $clog2(DIGITS+1): number of digits entered.
- `fifo_level` out $clog2(DEPTH+1): FIFO occupancy.
- `drop` out 1: one-cycle pulse when a key is lost because the FIFO is full.
- `sat` out 1: one-cycle pulse when a digit is ignored because of the digit limit or ANS lock.

## Operation
- Entry state:
  - `mag` is the WIDTH-bit magnitude, `neg` is the sign flag, `cnt` is the digit count.
  - `mode` is one of EMPTY, DIGIT, ANS or HOLD.
  - `disp_value` = `neg` ? -`mag` : `mag`.
- FIFO:
  - A push occurs on `key_valid` when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the key is discarded and `drop` pulses.
  - At most one pop per cycle. No pop while `mode`=HOLD.
- Token handling by mode:
  - **Digit d, mode EMPTY/DIGIT:**
    - Digit limit is DIGITS-`neg`.
    - If `cnt` < limit: `mag` ← `mag`·10+d and mode ← DIGIT. `cnt` increments unless `mag`=0 and d=0; leading zeros are not counted.
    - Else: the digit is ignored and `sat` pulses.
  - **Digit in mode ANS:** ignored; `sat` pulses.
  - **`c` in mode EMPTY:** `neg` toggles.
  - **`d` (backspace):**
    - DIGIT: `mag` ← `mag`/10 and `cnt`--. If `cnt` reaches 0, mode ← EMPTY.
    - ANS: the entry clears to EMPTY and `neg` is kept.
    - EMPTY: `neg` ← 0.
  - **`e` (ANS):**
    - `mag` ← |`ans|`, `neg` ← `neg` XOR `ans`[MSB], mode ← ANS.
    - Most-negative `ans` wraps with no flag.
  - **`a`, `b`, `f`, and `c` in mode DIGIT/ANS:** operator tokens.
    - Load `tok_code`, `tok_operand` = `disp_value` and `tok_empty` = (mode==EMPTY).
    - Then mode ← HOLD and `tok_valid` ← 1.
- **HOLD:**
  - `tok_*` outputs stay stable until `tok_valid`&&`tok_ready`.
  - On that handshake cycle: `tok_valid` ← 0, and `mag`, `neg`, `cnt` ← 0, mode ← EMPTY.
- **`clear`:** empties the FIFO, zeroes the entry, sets `tok_valid` ← 0 and mode ← EMPTY. It has priority over push, pop and handshake in the same cycle.
- **Reset:**
  - All outputs are 0: `tok_valid`, `tok_code`, `tok_operand`, `tok_empty`, `disp_value`, `ndigits`, `fifo_level`, `drop`, `sat`.
  - FIFO pointers are 0 and mode is EMPTY.
  - A reset mid-operation discards FIFO contents and any pending token immediately.

## Timing
- Pipeline:
  - Cycle n: key push.
  - Cycle n+1: earliest pop.
  - Cycle n+2: `disp_value`, `ndigits` or `tok_valid` updated.
- Throughput is one token per cycle outside HOLD.
- Handshake:
  - `tok_valid` may assert regardless of `tok_ready`.
  - The next pop occurs no earlier than the cycle after the handshake.
- `fifo_level` is registered. A simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- `drop` and `sat` are single-cycle registered pulses.

## Test plan
- Keys 0,1,2,3 → `disp_value`=123, `ndigits`=3. Then `b` with `tok_ready`=1 → token `b`/123, `tok_empty`=0; entry returns to 0.
- Keys `c`,4,5,`a`, with `tok_ready` held low for 3 cycles → `disp_value`=-45. `tok_valid` is stable for 3 cycles with operand -45 and no pops; after the handshake the entry is 0.
- Digit limit:
  - Keys 1..7 → 123456 and `sat` pulses once.
  - Keys `c`,1..6 → -12345 and `sat` pulses once.
  - Keys 1,2,3,`d` → 12, `ndigits` 2.
- ANS path: `ans`=-77, keys `c`,`e`,5,`f` → `disp_value`=77 and `sat` pulses on the 5; token `f`/77. A bare `f` → `tok_empty`=1, operand 0.
- FIFO overflow (DEPTH=8): hold a token pending with `tok_ready`=0 and push 9 keys → `fifo_level`=8 and `drop` pulses on key 9. Then release `tok_ready` and push in the same cycle as a pop → the key is accepted and the level stays 8.
- Assert `rst` low mid-entry with 3 queued keys → all outputs are 0 immediately. After release, key 7 → 7. Repeat with `clear` → the same result, synchronously.
